// File: rtl/safe_lock_ctrl.sv
// Safe lock controller: frames upstream code-check results into attempts,
// drives unlock/lockout windows and counts consecutive failures.
// Ports: clk, rstn (async low); res_val/res_data result stream; relock;
// alarm_clr; unlock, lockout, alarm, attempt_pass, attempt_fail, fail_cnt.
// Optional latched alarm: define SAFE_LOCK_ALARM_EN.
module safe_lock_ctrl #(
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int MAX_FAILS      = 3,
  localparam int FW   = $clog2(MAX_FAILS + 1),
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                        UNLOCK_CYCLES : LOCKOUT_CYCLES,
  localparam int TW   = $clog2(TMAX + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          res_val,
  input  logic          res_data,
  input  logic          relock,
  input  logic          alarm_clr,
  output logic          unlock,
  output logic          lockout,
  output logic          alarm,
  output logic          attempt_pass,
  output logic          attempt_fail,
  output logic [FW-1:0] fail_cnt
);

  typedef enum logic [1:0] {
    S_LOCKED,
    S_UNLOCKED,
    S_LOCKOUT
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [FW-1:0]   cnt_n;
  logic            pass_n, fail_n;
  logic            res_val_d;
  logic            run_ok;
  logic            run_hit;
  logic            run_end;
  logic            accept;

  // run_ok remembers whether the run began in LOCKED
  assign run_end = res_val_d & ~res_val;
  assign accept  = run_end & run_ok & (state == S_LOCKED);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_val_d <= 1'b0;
      run_ok    <= 1'b0;
      run_hit   <= 1'b0;
    end else begin
      res_val_d <= res_val;
      if (res_val && !res_val_d) begin
        run_ok  <= (state == S_LOCKED);
        run_hit <= res_data;
      end else if (res_val) begin
        run_hit <= run_hit | res_data;
      end else begin
        run_ok  <= 1'b0;
        run_hit <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    cnt_n   = fail_cnt;
    pass_n  = 1'b0;
    fail_n  = 1'b0;
    unique case (state)
      S_LOCKED: begin
        if (accept) begin
          if (run_hit) begin
            state_n = S_UNLOCKED;
            timer_n = TW'(UNLOCK_CYCLES);
            cnt_n   = '0;
            pass_n  = 1'b1;
          end else begin
            fail_n = 1'b1;
            if (fail_cnt == FW'(MAX_FAILS - 1)) begin
              state_n = S_LOCKOUT;
              timer_n = TW'(LOCKOUT_CYCLES);
              cnt_n   = FW'(MAX_FAILS);
            end else begin
              cnt_n = fail_cnt + 1'b1;
            end
          end
        end
      end
      S_UNLOCKED: begin
        if (relock || timer <= TW'(1)) begin
          state_n = S_LOCKED;
          timer_n = '0;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      S_LOCKOUT: begin
        if (timer <= TW'(1)) begin
          state_n = S_LOCKED;
          timer_n = '0;
          cnt_n   = '0;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: begin
        state_n = S_LOCKED;
        timer_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_LOCKED;
      timer        <= '0;
      fail_cnt     <= '0;
      unlock       <= 1'b0;
      lockout      <= 1'b0;
      attempt_pass <= 1'b0;
      attempt_fail <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      fail_cnt     <= cnt_n;
      unlock       <= (state_n == S_UNLOCKED);
      lockout      <= (state_n == S_LOCKOUT);
      attempt_pass <= pass_n;
      attempt_fail <= fail_n;
    end
  end

`ifdef SAFE_LOCK_ALARM_EN
  // set has priority over clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alarm <= 1'b0;
    end else if (state_n == S_LOCKOUT && state != S_LOCKOUT) begin
      alarm <= 1'b1;
    end else if (alarm_clr) begin
      alarm <= 1'b0;
    end
  end
`else
  logic unused_alarm_clr;
  assign unused_alarm_clr = alarm_clr;
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed self-checking bench for safe_lock_ctrl.
// Default parameters: unlock 8, lockout 16, 3 fails.
module tb_safe_lock_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       res_val, res_data, relock, alarm_clr;
  logic       unlock, lockout, alarm;
  logic       attempt_pass, attempt_fail;
  logic [1:0] fail_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int n;

`ifdef SAFE_LOCK_ALARM_EN
  localparam logic ALARM_ON = 1'b1;
`else
  localparam logic ALARM_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  safe_lock_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .res_val      (res_val),
    .res_data     (res_data),
    .relock       (relock),
    .alarm_clr    (alarm_clr),
    .unlock       (unlock),
    .lockout      (lockout),
    .alarm        (alarm),
    .attempt_pass (attempt_pass),
    .attempt_fail (attempt_fail),
    .fail_cnt     (fail_cnt)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // len cycles of res_val, res_data on the last one if hit, then a gap
  task automatic attempt(input int len, input bit hit);
    for (int i = 0; i < len; i++) begin
      res_val  = 1'b1;
      res_data = hit && (i == len - 1);
      step();
    end
    res_val  = 1'b0;
    res_data = 1'b0;
    step();
  endtask

  task automatic measure(input bit sel_lockout, output int cnt);
    cnt = 0;
    while ((sel_lockout ? lockout : unlock) && cnt < 100) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    rstn = 1'b0; res_val = 0; res_data = 0; relock = 0; alarm_clr = 0;
    step(); step();
    chk("rst_unlock", unlock, 0);
    chk("rst_lockout", lockout, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_pass", attempt_pass, 0);
    chk("rst_fail", attempt_fail, 0);
    chk("rst_cnt", fail_cnt, 0);
    rstn = 1'b1;
    step();

    // correct attempt
    attempt(4, 1);
    chk("t1_pass", attempt_pass, 1);
    chk("t1_unlock", unlock, 1);
    chk("t1_cnt", fail_cnt, 0);
    step();
    chk("t1_pass_1cyc", attempt_pass, 0);
    measure(0, n);
    chk("t1_unlock_len", n + 1, 8);
    step();

    // two fails then pass, back-to-back
    attempt(3, 0);
    chk("t2_fail1", attempt_fail, 1);
    chk("t2_cnt1", fail_cnt, 1);
    attempt(2, 0);
    chk("t2_fail2", attempt_fail, 1);
    chk("t2_cnt2", fail_cnt, 2);
    attempt(2, 1);
    chk("t2_pass", attempt_pass, 1);
    chk("t2_cnt0", fail_cnt, 0);
    chk("t2_unlock", unlock, 1);
    measure(0, n);
    chk("t2_unlock_len", n, 8);

    // lockout
    attempt(2, 0);
    attempt(2, 0);
    attempt(2, 0);
    chk("t3_fail3", attempt_fail, 1);
    chk("t3_lockout", lockout, 1);
    chk("t3_cnt3", fail_cnt, 3);
    chk("t3_alarm", alarm, ALARM_ON);
    measure(1, n);
    chk("t3_lockout_len", n, 16);
    chk("t3_cnt_after", fail_cnt, 0);
    chk("t3_alarm_hold", alarm, ALARM_ON);
    alarm_clr = 1'b1;
    step();
    alarm_clr = 1'b0;
    chk("t3_alarm_clr", alarm, 0);

    // correct attempt during lockout is ignored
    attempt(2, 0);
    attempt(2, 0);
    attempt(2, 0);
    chk("t4_lockout", lockout, 1);
    attempt(2, 1);
    chk("t4_no_pass", attempt_pass, 0);
    chk("t4_no_unlock", unlock, 0);
    chk("t4_still_lockout", lockout, 1);
    measure(1, n);
    chk("t4_lockout_rest", n, 13);
    chk("t4_cnt_after", fail_cnt, 0);
    chk("t4_no_unlock_after", unlock, 0);
    chk("t4_alarm", alarm, ALARM_ON);
    alarm_clr = 1'b1;
    step();
    alarm_clr = 1'b0;

    // relock ignored while locked, then relock 3 cycles into unlock
    relock = 1'b1;
    step();
    relock = 1'b0;
    chk("t5_relock_locked", unlock, 0);
    attempt(2, 1);
    chk("t5_unlock", unlock, 1);
    step(); step();
    relock = 1'b1;
    step();
    relock = 1'b0;
    chk("t5_relock_drop", unlock, 0);
    attempt(2, 1);
    measure(0, n);
    chk("t5_unlock_full", n, 8);

    // attempt started in unlock, ending on expiry cycle, is discarded
    attempt(2, 1);
    for (int i = 0; i < 7; i++) begin
      res_val  = 1'b1;
      res_data = 1'b1;
      step();
    end
    chk("t6_unlock_last", unlock, 1);
    res_val  = 1'b0;
    res_data = 1'b0;
    step();
    chk("t6_unlock_off", unlock, 0);
    chk("t6_no_pass", attempt_pass, 0);
    chk("t6_no_fail", attempt_fail, 0);

    // reset mid-unlock with a half-entered attempt
    step();
    attempt(2, 1);
    res_val  = 1'b1;
    res_data = 1'b1;
    step();
    rstn = 1'b0;
    #1;
    res_val  = 1'b0;
    res_data = 1'b0;
    chk("t7_rst_unlock", unlock, 0);
    chk("t7_rst_pass", attempt_pass, 0);
    #2 rstn = 1'b1;
    step();
    chk("t7_no_pass", attempt_pass, 0);
    chk("t7_no_unlock", unlock, 0);

    // reset mid-lockout
    attempt(2, 0);
    attempt(2, 0);
    attempt(2, 0);
    step();
    rstn = 1'b0;
    #1;
    chk("t8_rst_lockout", lockout, 0);
    chk("t8_rst_cnt", fail_cnt, 0);
    chk("t8_rst_alarm", alarm, 0);
    #2 rstn = 1'b1;
    step();
    chk("t8_lockout_off", lockout, 0);
    attempt(2, 1);
    chk("t8_pass", attempt_pass, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
